// File: rtl/div3_result_collector.sv
// div3_result_collector
//   Valid/ready wrapper around a fixed-latency, registered divide-by-3 unit.
//   Accepted operands are sent to the divider and tracked through a tag pipe
//   that matches the divider's latency. Each returning quotient is paired with
//   its operand, a remainder is derived, and the {x, q, r} triple is pushed
//   into a first-word-fall-through FIFO. Admission is credit based: an operand
//   is taken only when the FIFO has room for it and for everything still
//   inside the divider, so a result is never dropped.
//
// Optional feature (macro DIV3_REM_CHECK_EN):
//   When defined, every FIFO write checks that x - 3*q lies in 0..2 and sets a
//   sticky err flag otherwise. When undefined, err is tied to 0.
//
// Ports
//   clk        rising-edge clock, shared with the divider
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   operand accepted when in_valid && in_ready
//   in_x       operand
//   div_x      operand to the divider (0 when nothing is accepted)
//   q_in       quotient returned by the divider, LAT cycles after div_x
//   out_valid  FIFO head valid
//   out_ready  consumer pops the head when out_valid && out_ready
//   out_x      head operand
//   out_q      head quotient
//   out_r      head remainder
//   err        sticky remainder-check error
//   level      FIFO occupancy
module div3_result_collector #(
  parameter int unsigned W_X   = 16,
  parameter int unsigned W_Q   = 15,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_X-1:0]             in_x,
  output logic [W_X-1:0]             div_x,
  input  logic [W_Q-1:0]             q_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W_X-1:0]             out_x,
  output logic [W_Q-1:0]             out_q,
  output logic [1:0]                 out_r,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned CW  = $clog2(DEPTH + LAT + 1);
  localparam int unsigned W_D = W_X + 2;

  typedef struct packed {
    logic [W_X-1:0] x;
    logic [W_Q-1:0] q;
    logic [1:0]     r;
  } entry_t;

  logic [LAT-1:0] tag_vld;
  logic [W_X-1:0] tag_x [LAT];
  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  fill;
  logic [CW-1:0]  inflight;
  logic           accept;
  logic           push;
  logic           pop;
  logic           empty;
  logic [W_D-1:0] d;
  entry_t         wr_entry;
  entry_t         head;

  // Operands still inside the divider reserve FIFO space
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      inflight = inflight + CW'(tag_vld[i]);
    end
  end

  // Occupancy and handshake; a same-cycle pop is deliberately not credited
  always_comb begin
    fill     = wr_ptr - rd_ptr;
    empty    = (wr_ptr == rd_ptr);
    in_ready = !rst && ((CW'(fill) + inflight) < CW'(DEPTH));
    accept   = in_valid && in_ready;
    div_x    = accept ? in_x : '0;
    push     = tag_vld[LAT-1];
    out_valid = !rst && !empty;
    level    = rst ? '0 : fill;
    pop      = out_valid && out_ready;
  end

  // Remainder from the returning quotient, wide enough to expose a bad q
  always_comb begin
    d          = W_D'(tag_x[LAT-1]) - W_D'(W_D'(q_in) * W_D'(3));
    wr_entry.x = tag_x[LAT-1];
    wr_entry.q = q_in;
    wr_entry.r = d[1:0];
    head       = mem[rd_ptr[AW-1:0]];
    out_x      = head.x;
    out_q      = head.q;
    out_r      = head.r;
  end

  // Tag valid pipe and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      tag_vld[0] <= accept;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_vld[i] <= tag_vld[i-1];
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Operand side of the tag pipe and FIFO storage carry no reset
  always_ff @(posedge clk) begin
    tag_x[0] <= div_x;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_x[i] <= tag_x[i-1];
    end
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

`ifdef DIV3_REM_CHECK_EN
  // Sticky flag: remainder outside 0..2 means the quotient was wrong
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (push && (d[W_D-1] || (d[W_D-2:0] > (W_D-1)'(2)))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_d_hi;
  assign unused_d_hi = ^d[W_D-1:2];
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_div3_result_collector.sv
// Self-checking bench for div3_result_collector. A two-stage registered
// divide-by-3 stands in for the real divider; results are predicted by a
// queue model that only knows: accept when fewer than DEPTH results are
// outstanding, each result becomes visible 3 cycles after its accept, q=x/3.
module tb_div3_result_collector;

  localparam int unsigned W_X   = 16;
  localparam int unsigned W_Q   = 15;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W_X-1:0] in_x;
  logic [W_X-1:0] div_x;
  logic [W_Q-1:0] q_in;
  logic           out_valid;
  logic           out_ready;
  logic [W_X-1:0] out_x;
  logic [W_Q-1:0] out_q;
  logic [1:0]     out_r;
  logic           err;
  logic [3:0]     level;

  div3_result_collector #(.W_X(W_X), .W_Q(W_Q), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .div_x(div_x), .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_q(out_q), .out_r(out_r), .err(err), .level(level)
  );

  always #5 clk = ~clk;

  // Divider stand-in with optional corruption of the quotient for x=100
  logic [W_Q-1:0] dq1, dq2;
  logic [W_X-1:0] dx1, dx2;
  logic           corrupt_en;
  always @(posedge clk) begin
    dq1 <= W_Q'(div_x / 3);
    dq2 <= dq1;
    dx1 <= div_x;
    dx2 <= dx1;
  end
  assign q_in = (corrupt_en && dx2 == 16'd100) ? 15'd34 : dq2;

  typedef struct {
    int x;
    int rdy;
    bit bad;
  } item_t;

  item_t mq[$];
  int    cyc;
  int    n_chk;
  int    n_fail;
  bit    err_exp;
  bit    last_acc;
  int    acc_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: check against the model mid-cycle, update it, advance
  task automatic tick();
    int  lvl;
    int  eq;
    int  er;
    bit  acc;
    bit  popd;
    #3;
    lvl = 0;
    foreach (mq[i]) begin
      if (mq[i].rdy <= cyc) begin
        lvl++;
`ifdef DIV3_REM_CHECK_EN
        if (mq[i].rdy == cyc && mq[i].bad) err_exp = 1'b1;
`endif
      end
    end
    last_acc = 1'b0;
    if (rst) begin
      chk("in_ready_rst", 32'(in_ready), 32'd0);
      chk("out_valid_rst", 32'(out_valid), 32'd0);
      chk("level_rst", 32'(level), 32'd0);
      chk("div_x_rst", 32'(div_x), 32'd0);
      mq.delete();
      err_exp = 1'b0;
    end else begin
      acc  = in_valid && (mq.size() < int'(DEPTH));
      popd = (lvl > 0) && out_ready;
      chk("in_ready", 32'(in_ready), 32'(mq.size() < int'(DEPTH)));
      chk("div_x", 32'(div_x), acc ? 32'(in_x) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(lvl > 0));
      chk("level", 32'(level), 32'(lvl));
      chk("err", 32'(err), 32'(err_exp));
      if (lvl > 0) begin
        eq = mq[0].bad ? 34 : mq[0].x / 3;
        er = (mq[0].x - 3 * eq) & 3;
        chk("out_x", 32'(out_x), 32'(mq[0].x));
        chk("out_q", 32'(out_q), 32'(eq));
        chk("out_r", 32'(out_r), 32'(er));
      end
      if (popd) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{x: int'(in_x), rdy: cyc + 3, bad: corrupt_en && in_x == 16'd100});
        last_acc = 1'b1;
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int x;
    bit err_want;
    n_chk = 0; n_fail = 0; cyc = 0; err_exp = 1'b0; acc_cnt = 0; last_acc = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0; corrupt_en = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;

    // Single operand: visible exactly three cycles after accept
    in_valid = 1'b1; in_x = 16'd100;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_q", 32'(out_q), 32'd33);
    chk("t1_out_r", 32'(out_r), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    tick(); tick();

    // Boundary operands back to back
    in_valid = 1'b1;
    in_x = 16'd65535; tick();
    in_x = 16'd0;     tick();
    in_x = 16'd2;     tick();
    in_valid = 1'b0;
    chk("t2_q0", 32'(out_q), 32'd21845);
    chk("t2_r0", 32'(out_r), 32'd0);
    tick();
    chk("t2_x1", 32'(out_x), 32'd0);
    chk("t2_q1", 32'(out_q), 32'd0);
    tick();
    chk("t2_x2", 32'(out_x), 32'd2);
    chk("t2_r2", 32'(out_r), 32'd2);
    tick();
    chk("t2_empty", 32'(out_valid), 32'd0);

    // Fill with consumer stalled: exactly DEPTH operands admitted
    out_ready = 1'b0; acc_cnt = 0; x = 1;
    in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_x = 16'(x);
      tick();
      if (last_acc && x < 12) x++;
    end
    chk("t3_accepts", 32'(acc_cnt), 32'd8);
    chk("t3_level", 32'(level), 32'd8);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t3_drained", 32'(level), 32'd0);

    // Sustained streaming, one result per cycle
    acc_cnt = 0; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_x = 16'($urandom);
      tick();
      chk("t4_level_le1", 32'(level <= 4'd1), 32'd1);
    end
    in_valid = 1'b0;
    chk("t4_accepts", 32'(acc_cnt), 32'd100);
    for (int i = 0; i < 5; i++) tick();

    // Random valid/ready with operand held while not accepted
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_x     = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Reset with results buffered and in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_x = 16'(1000 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_level_pre", 32'(level), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b1; in_x = 16'd777;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t5_new_valid", 32'(out_valid), 32'd1);
    chk("t5_new_q", 32'(out_q), 32'd259);
    tick();

    // Corrupted quotient: sticky err when the check is built in
`ifdef DIV3_REM_CHECK_EN
    err_want = 1'b1;
`else
    err_want = 1'b0;
`endif
    corrupt_en = 1'b1;
    in_valid = 1'b1; in_x = 16'd100;
    tick();
    in_valid = 1'b0;
    chk("t6_err_before", 32'(err), 32'd0);
    tick(); tick();
    chk("t6_err_set", 32'(err), 32'(err_want));
    chk("t6_bad_q", 32'(out_q), 32'd34);
    in_valid = 1'b1;
    in_x = 16'd5; tick();
    in_x = 16'd6; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_err_sticky", 32'(err), 32'(err_want));
    rst = 1'b1;
    tick();
    rst = 1'b0; corrupt_en = 1'b0;
    chk("t6_err_cleared", 32'(err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
